// File: rtl/ahfp_mult_arbiter_if.sv
// Request/response bundle for ahfp_mult_arbiter.
// Packed operand lanes: requester i occupies bits [32i+31:32i].
interface ahfp_mult_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]    req_valid;
  logic [32*N_REQ-1:0] req_dataa;
  logic [32*N_REQ-1:0] req_datab;
  logic [N_REQ-1:0]    req_ready;
  logic                rsp_valid;
  logic [ID_W-1:0]     rsp_id;
  logic [31:0]         rsp_result;
  logic                rsp_ready;

  modport master (
    output req_valid, req_dataa, req_datab, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result
  );

  modport slave (
    input  req_valid, req_dataa, req_datab, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result
  );
endinterface

// File: rtl/ahfp_mult_arbiter.sv
// Round-robin share of one combinational ahfp_mult across N_REQ lanes.
// Define AHFP_ARB_FASTPATH_EN to overlap response release with next grant.
module ahfp_mult_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic        clk,
  input  logic        reset,
  ahfp_mult_arbiter_if.slave bus,
  output logic [31:0] mult_dataa,
  output logic [31:0] mult_datab,
  input  logic [31:0] mult_result,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] last_q, last_d;
  logic [ID_W-1:0] tag_q, tag_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  logic [31:0]     res_q, res_d;
  logic            rv_q, rv_d;
  logic [ID_W-1:0] rid_q, rid_d;

  logic [ID_W-1:0] win_idx;
  logic            win_vld;
  logic            grant_en;
  logic            accept;

  // Scan downward so the nearest candidate after last_q wins.
  always_comb begin : rr_pick
    int              pos;
    logic [ID_W-1:0] sel;
    pos     = 0;
    sel     = '0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      pos = (int'(last_q) + k) % N_REQ;
      sel = ID_W'(pos);
      if (bus.req_valid[sel]) begin
        win_vld = 1'b1;
        win_idx = sel;
      end
    end
  end

`ifdef AHFP_ARB_FASTPATH_EN
  assign grant_en = !reset &&
                    ((state_q == IDLE) ||
                     (state_q == RESP && bus.rsp_ready));
`else
  assign grant_en = !reset && (state_q == IDLE);
`endif

  assign accept = grant_en && win_vld;

  assign bus.req_ready = accept ? (N_REQ'(1) << win_idx)
                                : '0;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    tag_d   = tag_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    rv_d    = rv_q;
    rid_d   = rid_q;
    if (accept) begin
      a_d    = bus.req_dataa[{win_idx, 5'b0} +: 32];
      b_d    = bus.req_datab[{win_idx, 5'b0} +: 32];
      tag_d  = win_idx;
      last_d = win_idx;
    end
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = MUL;
      end
      MUL: begin
        res_d   = mult_result;
        rid_d   = tag_q;
        rv_d    = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rv_d    = 1'b0;
          state_d = accept ? MUL : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= ID_W'(N_REQ - 1);
      tag_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      rv_q    <= 1'b0;
      rid_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      tag_q   <= tag_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      rv_q    <= rv_d;
      rid_q   <= rid_d;
    end
  end

  assign mult_dataa     = a_q;
  assign mult_datab     = b_q;
  assign bus.rsp_valid  = rv_q;
  assign bus.rsp_id     = rid_q;
  assign bus.rsp_result = res_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_ahfp_mult_arbiter.sv
// Scoreboard bench for ahfp_mult_arbiter with a stub multiplier.
// Round-robin and timing expectations come from a queue-based model.
module tb_ahfp_mult_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;
`ifdef AHFP_ARB_FASTPATH_EN
  localparam int PERIOD = 2;
`else
  localparam int PERIOD = 3;
`endif

  typedef struct {
    int          id;
    logic [31:0] res;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mult_dataa;
  logic [31:0] mult_datab;
  logic [31:0] mult_result;
  logic        busy;

  ahfp_mult_arbiter_if #(.N_REQ(N), .ID_W(IW)) bus();

  ahfp_mult_arbiter #(.N_REQ(N), .ID_W(IW)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .mult_dataa  (mult_dataa),
    .mult_datab  (mult_datab),
    .mult_result (mult_result),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Stub multiplier: known vectors, identity, zero, else a hash.
  function automatic logic [31:0] ref_mul(
    logic [31:0] a, logic [31:0] b);
    if (a == 32'h0 || b == 32'h0) return 32'h0;
    if (a == 32'h3F800000) return b;
    if (b == 32'h3F800000) return a;
    if (a == 32'h00C00001 && b == 32'h00C00000)
      return 32'h01400001;
    if (a == 32'h00C00000 && b == 32'h00C00000)
      return 32'h01400000;
    return (a ^ {b[15:0], b[31:16]}) + 32'h9E3779B9;
  endfunction

  assign mult_result = ref_mul(mult_dataa, mult_datab);

  function automatic int rr_pick(logic [N-1:0] v, int last);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (v[i[IW-1:0]]) return i;
    end
    return -1;
  endfunction

  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [63:0] ops [N][$];
  int          fire_cnt [N] = '{default: 0};
  exp_t        sb [$];
  logic        chk_period;
  logic        timeout_flag;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(string name,
                       logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Requester driver: each lane presents the head of its queue.
  initial begin
    bus.req_valid = '0;
    bus.req_dataa = '0;
    bus.req_datab = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (fire_cnt[i] < ops[i].size()) begin
          bus.req_valid[i] = 1'b1;
          bus.req_dataa[32*i +: 32] = ops[i][fire_cnt[i]][63:32];
          bus.req_datab[32*i +: 32] = ops[i][fire_cnt[i]][31:0];
        end else begin
          bus.req_valid[i] = 1'b0;
        end
      end
    end
  end

  // Monitor: grant model, scoreboard push/pop, hold and reset checks.
  always @(negedge clk) begin : mon
    logic [N-1:0] exp_rdy;
    logic [N-1:0] hs;
    logic         can;
    int           w;
    exp_t         e;
    static int          model_last = N - 1;
    static int          last_app = -1;
    static logic        prev_reset = 1'b0;
    static logic        held = 1'b0;
    static logic        ops_chk = 1'b0;
    static logic [31:0] ops_a = '0;
    static logic [31:0] ops_b = '0;
    static logic [IW-1:0] h_id = '0;
    static logic [31:0] h_res = '0;

    if (ops_chk) begin
      check("mult_dataa", mult_dataa, ops_a);
      check("mult_datab", mult_datab, ops_b);
      check("busy_in_mul", {31'b0, busy}, 32'd1);
      ops_chk = 1'b0;
    end

    if (prev_reset) begin
      check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
      check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
      check("rst_rsp_result", bus.rsp_result, 32'd0);
      check("rst_mult_dataa", mult_dataa, 32'd0);
      check("rst_mult_datab", mult_datab, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
    end

`ifdef AHFP_ARB_FASTPATH_EN
    can = !reset && (!busy || (bus.rsp_valid && bus.rsp_ready));
`else
    can = !reset && !busy;
`endif
    w = rr_pick(bus.req_valid, model_last);
    exp_rdy = '0;
    if (can && w >= 0) exp_rdy = N'(1) << w;
    check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));

    hs = bus.req_valid & bus.req_ready;
    if (!reset && hs != '0) begin
      w = -1;
      for (int i = 0; i < N; i++)
        if (hs[i[IW-1:0]]) w = i;
      ops_a = bus.req_dataa[32*w +: 32];
      ops_b = bus.req_datab[32*w +: 32];
      ops_chk = 1'b1;
      e.id  = w;
      e.res = ref_mul(ops_a, ops_b);
      e.cyc = cyc + 2;
      sb.push_back(e);
      fire_cnt[w] = fire_cnt[w] + 1;
      model_last = w;
    end

    if (bus.rsp_valid) begin
      if (held) begin
        check("hold_rsp_id", 32'(bus.rsp_id), 32'(h_id));
        check("hold_rsp_result", bus.rsp_result, h_res);
        check("hold_busy", {31'b0, busy}, 32'd1);
      end else if (sb.size() == 0) begin
        check("spurious_rsp", {31'b0, bus.rsp_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_id", 32'(bus.rsp_id), 32'(e.id));
        check("rsp_result", bus.rsp_result, e.res);
        check("rsp_latency", 32'(cyc), 32'(e.cyc));
        if (chk_period && last_app >= 0)
          check("rsp_period", 32'(cyc - last_app), 32'(PERIOD));
        last_app = cyc;
      end
      h_id  = bus.rsp_id;
      h_res = bus.rsp_result;
    end
    if (!chk_period) last_app = -1;
    held = bus.rsp_valid && !bus.rsp_ready && !reset;

    if (reset) begin
      sb.delete();
      model_last = N - 1;
    end
    prev_reset = reset;
    check("timeout", {31'b0, timeout_flag}, 32'd0);
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(int r, logic [31:0] a, logic [31:0] b);
    ops[r].push_back({a, b});
  endtask

  function automatic logic pending();
    for (int i = 0; i < N; i++)
      if (fire_cnt[i] < ops[i].size()) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_idle(int budget);
    int t;
    t = 0;
    while (pending() || busy || bus.rsp_valid || sb.size() != 0) begin
      step(1);
      t++;
      if (t > budget) begin
        timeout_flag = 1'b1;
        break;
      end
    end
    step(1);
  endtask

  task automatic wait_busy(int budget);
    int t;
    t = 0;
    while (!busy) begin
      step(1);
      t++;
      if (t > budget) begin
        timeout_flag = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset(int n);
    reset = 1'b1;
    step(n);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.rsp_ready = 1'b1;
    chk_period = 1'b0;
    timeout_flag = 1'b0;
    step(3);

    // first request waits out reset, then wins immediately
    push(0, 32'h00C00001, 32'h00C00000);
    step(2);
    reset = 1'b0;
    wait_idle(50);

    // all lanes valid: rotation and steady throughput
    do_reset(2);
    chk_period = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++)
        push(i, 32'h3F800000, 32'h40000000 + 32'(i + 4*r));
    wait_idle(100);
    chk_period = 1'b0;

    // backpressure hold with a competing lane pending
    bus.rsp_ready = 1'b0;
    push(2, 32'h00C00000, 32'h00C00000);
    wait_busy(20);
    push(0, 32'h12345678, 32'h3F800000);
    step(7);
    bus.rsp_ready = 1'b1;
    wait_idle(50);

    // sparse lanes 1 and 3 after a grant to 3
    push(3, 32'h40400000, 32'h3F800000);
    wait_idle(50);
    push(1, 32'h11111111, 32'h22222222);
    push(1, 32'h33333333, 32'h44444444);
    push(3, 32'h55555555, 32'h66666666);
    push(3, 32'h77777777, 32'h88888888);
    wait_idle(100);

    // reset while the multiplier holds lane 3
    push(3, 32'h40400000, 32'h40800000);
    wait_busy(20);
    do_reset(2);
    push(2, 32'h40A00000, 32'h3F800000);
    wait_idle(50);

    push(1, 32'h00000000, 32'h00000000);
    wait_idle(50);

    // random traffic and backpressure
    for (int c = 0; c < 300; c++) begin
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0)
        push(int'($urandom_range(0, N - 1)), $urandom, $urandom);
      step(1);
    end
    bus.rsp_ready = 1'b1;
    wait_idle(2000);

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/ahfp_mult_arbiter.md
# ahfp_mult_arbiter

Round-robin arbiter that shares one combinational `ahfp_mult` floating-point multiplier between `N_REQ` requesters.
- Each requester presents an operand pair with a valid/ready handshake.
- The arbiter grants one requester at a time and registers the winner's operands onto the multiplier inputs.
- It captures the product and returns it on a single tagged response channel with backpressure.
- Sits between the compute lanes and the single multiplier instance in the datapath.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `ID_W`, default 2: response tag width, equal to clog2(`N_REQ`).
- `clk` in, 1: clock; all logic on the rising edge.
- `reset` in, 1: synchronous, active-high reset.
- `req_valid` in, `N_REQ`: bit i set means requester i has an operand pair pending.
- `req_dataa` in, 32*`N_REQ`: operand A; requester i in bits [32i+31:32i].
- `req_datab` in, 32*`N_REQ`: operand B, same packing.
- `req_ready` out, `N_REQ`: one-hot grant; the transfer happens on an edge where `req_valid[i]` and `req_ready[i]` are both high.
- `mult_dataa` out, 32: registered operand A to the multiplier `dataa`.
- `mult_datab` out, 32: registered operand B to the multiplier `datab`.
- `mult_result` in, 32: multiplier `result`, combinational from `mult_dataa`/`mult_datab`.
- `rsp_valid` out, 1: response valid.
- `rsp_id` out, `ID_W`: index of the requester that owns the response.
- `rsp_result` out, 32: registered product.
- `rsp_ready` in, 1: consumer accepts the response.
- `busy` out, 1: high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, MUL, RESP.
- **IDLE**
  - If any `req_valid` bit is set, `req_ready` is combinationally the one-hot winner; otherwise it is 0.
  - Winner: the first set bit searching upward from `last_grant+1`, wrapping modulo `N_REQ`.
  - On the accepting edge: latch the winner's operands into `mult_dataa`/`mult_datab`, latch the tag, set `last_grant`=winner, go to MUL.
- **MUL**
  - `req_ready` = 0.
  - On the next edge: `rsp_result` <= `mult_result`, `rsp_id` <= tag, `rsp_valid` <= 1, go to RESP.
- **RESP**
  - `rsp_valid`, `rsp_id` and `rsp_result` are held stable until the edge where `rsp_ready`=1.
  - On that edge `rsp_valid` <= 0 and the FSM goes to IDLE.
  - In the base configuration `req_ready` = 0 throughout RESP.
- `mult_dataa`/`mult_datab` keep their last values between transactions; they are never zeroed except by reset.
- `req_valid` bits that are not granted are ignored. A requester may drop `req_valid` before grant with no effect.
- Data is passed through bit-exact; the arbiter performs no arithmetic.

## Timing
- Reset values:
  - FSM = IDLE; `last_grant` = `N_REQ`-1, so requester 0 has first priority.
  - `req_ready` forced to 0 while `reset` is high.
  - `mult_dataa` = `mult_datab` = 0; `rsp_valid` = 0; `rsp_id` = 0; `rsp_result` = 0; `busy` = 0.
- Latency: accept at edge k means `rsp_valid`=1 after edge k+1.
- Throughput (base configuration): one transaction per 3 cycles with `rsp_ready` held high.
- `reset` asserted in MUL or RESP: the transaction in flight is dropped, there is no response, and the next grant goes to requester 0.
- When all `N_REQ` requesters are valid continuously, grants rotate 0,1,2,...,`N_REQ`-1,0 with no starvation.

## Configuration
- `AHFP_ARB_FASTPATH_EN` undefined: behaviour exactly as above.
- `AHFP_ARB_FASTPATH_EN` defined: in RESP, when `rsp_ready`=1 and any `req_valid` bit is set, `req_ready` presents the round-robin winner in the same cycle.
  - Both handshakes complete on the same edge; the FSM goes straight to MUL with the new operands latched.
  - Throughput becomes one transaction per 2 cycles.
  - With `rsp_ready`=0, `req_ready` stays 0, identical to the base configuration.

## Test plan
- Reset, then requester 0 sends 0x00C00001 x 0x00C00000 with `rsp_ready`=1 -> `req_ready`=4'b0001 in the first cycle; `rsp_valid` after 2 edges with `rsp_id`=0 and `rsp_result`=0x01400001.
- All 4 requesters valid continuously; requester i sends 0x3F800000 x (0x40000000 + i) -> `rsp_id` sequence 0,1,2,3,0; each result equals operand B; responses every 3 cycles, or every 2 with `AHFP_ARB_FASTPATH_EN`.
- Requester 2 sends 0x00C00000 x 0x00C00000 with `rsp_ready`=0 for 5 cycles -> `rsp_valid`=1, `rsp_id`=2 and `rsp_result`=0x01400000 held stable; `req_ready`=0 and `busy`=1 throughout; the response is released on the first `rsp_ready`=1 edge.
- Only requesters 1 and 3 valid, after a prior grant to 3 -> next grant goes to 1, then 3, then 1.
- Assert `reset` while in MUL with requester 3 granted -> no response; `rsp_valid`=0 and `mult_dataa`=0 after reset; a following request from requester 2 is granted with `rsp_id`=2.
- Zero operands 0x00000000 x 0x00000000 from requester 1 -> `rsp_result`=0x00000000, `rsp_id`=1.
